// File: rtl/encrypter_mem_arbiter_if.sv
// Request/command bundle between the image loader, VGA fetch, the arbiter and the image memory.
// master: requesters plus memory read data; slave: the arbiter itself.
interface encrypter_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  i_clear;
    logic                  o_busy;
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [ADDR_WIDTH-1:0] i_wr_addr;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  i_rd_valid;
    logic                  o_rd_ready;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_data_valid;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  o_mem_write;
    logic [DATA_WIDTH-1:0] o_mem_data;
    logic [DATA_WIDTH-1:0] i_mem_data;

    modport master (
        output i_clear, i_wr_valid, i_wr_addr, i_wr_data, i_rd_valid, i_rd_addr, i_mem_data,
        input  o_busy, o_wr_ready, o_rd_ready, o_rd_data, o_rd_data_valid,
               o_mem_addr, o_mem_write, o_mem_data
    );

    modport slave (
        input  i_clear, i_wr_valid, i_wr_addr, i_wr_data, i_rd_valid, i_rd_addr, i_mem_data,
        output o_busy, o_wr_ready, o_rd_ready, o_rd_data, o_rd_data_valid,
               o_mem_addr, o_mem_write, o_mem_data
    );
endinterface

// File: rtl/encrypter_mem_arbiter.sv
// Single-port image memory arbiter (loader writes vs VGA reads) with a bulk clear sweep.
// Command +1 cycle, read data valid +1+MEM_LAT; readies are combinational and both low while clearing.
module encrypter_mem_arbiter #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    DEPTH        = 256,
    parameter int                    MEM_LAT      = 1,
    parameter int                    MAX_RD_BURST = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input logic                    i_clk,
    input logic                    i_rst,
    encrypter_mem_arbiter_if.slave bus
);
    localparam int                    STREAK_W   = $clog2(MAX_RD_BURST + 1);
    localparam int                    CNT_W      = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      CLR_LAST   = CNT_W'(DEPTH - 1);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_RD_BURST);

    typedef enum logic {S_ARB, S_CLEAR} state_t;

    state_t                 state, state_nxt;
    logic [STREAK_W-1:0]    streak, streak_nxt;
    logic [CNT_W-1:0]       clr_cnt, clr_cnt_nxt;
    logic                   rd_gnt, wr_gnt;
    logic                   cmd_write;
    logic [ADDR_WIDTH-1:0]  cmd_addr, mem_addr_q;
    logic [DATA_WIDTH-1:0]  cmd_data, mem_data_q;
    logic                   mem_write_q;
    logic [MEM_LAT:0]       rd_pipe;

    always_comb begin
        state_nxt   = state;
        streak_nxt  = '0;
        clr_cnt_nxt = clr_cnt;
        rd_gnt      = 1'b0;
        wr_gnt      = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = mem_addr_q;
        cmd_data    = mem_data_q;
        case (state)
            S_ARB: begin
                // Reads win contention until the streak limit, then one write is forced through.
                rd_gnt = bus.i_rd_valid && (!bus.i_wr_valid || (streak < STREAK_MAX));
                wr_gnt = bus.i_wr_valid && !rd_gnt;
                if (rd_gnt) begin
                    streak_nxt = (streak < STREAK_MAX) ? streak + STREAK_W'(1) : STREAK_MAX;
                    cmd_addr   = bus.i_rd_addr;
                end else if (wr_gnt) begin
                    cmd_write = 1'b1;
                    cmd_addr  = bus.i_wr_addr;
                    cmd_data  = bus.i_wr_data;
                end
                if (bus.i_clear) begin
                    state_nxt   = S_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                cmd_write = 1'b1;
                cmd_addr  = clr_cnt[ADDR_WIDTH-1:0];
                cmd_data  = CLEAR_VALUE;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt   = S_ARB;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_ARB;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_ARB;
            streak      <= '0;
            clr_cnt     <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_write_q <= 1'b0;
            rd_pipe     <= '0;
        end else begin
            state       <= state_nxt;
            streak      <= streak_nxt;
            clr_cnt     <= clr_cnt_nxt;
            mem_addr_q  <= cmd_addr;
            mem_data_q  <= cmd_data;
            mem_write_q <= cmd_write;
            // Tracks only granted reads, so idle-cycle reads of the held address are never flagged.
            rd_pipe     <= {rd_pipe[MEM_LAT-1:0], rd_gnt};
        end
    end

    assign bus.o_busy          = (state == S_CLEAR);
    assign bus.o_rd_ready      = rd_gnt;
    assign bus.o_wr_ready      = wr_gnt;
    assign bus.o_mem_addr      = mem_addr_q;
    assign bus.o_mem_data      = mem_data_q;
    assign bus.o_mem_write     = mem_write_q;
    assign bus.o_rd_data       = bus.i_mem_data;
    assign bus.o_rd_data_valid = rd_pipe[MEM_LAT];
endmodule

// File: tb/tb_encrypter_mem_arbiter.sv
// Directed bench for encrypter_mem_arbiter with a 1-cycle-latency memory model behind it.
// Unwritten memory words read back as addr ^ 0x3C.
module tb_encrypter_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    encrypter_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    encrypter_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256), .MEM_LAT(1),
        .MAX_RD_BURST(4), .CLEAR_VALUE(8'h00)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    logic [DW-1:0] mem [256];
    logic [255:0]  wr_seen;
    logic [DW-1:0] mem_q;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_seen <= '0;
            mem_q   <= '0;
        end else begin
            if (bus.o_mem_write) begin
                mem[bus.o_mem_addr]     <= bus.o_mem_data;
                wr_seen[bus.o_mem_addr] <= 1'b1;
            end
            mem_q <= wr_seen[bus.o_mem_addr] ? mem[bus.o_mem_addr] : (bus.o_mem_addr ^ 8'h3C);
        end
    end
    assign bus.i_mem_data = mem_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        bus.i_clear    = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_rd_valid = 1'b0;
    endtask

    bit [9:0] w_pat;

    initial begin
        i_rst         = 1'b1;
        idle();
        bus.i_wr_addr = '0;
        bus.i_wr_data = '0;
        bus.i_rd_addr = '0;
        w_pat         = 10'b10_0001_0000;

        // Reset state
        @(negedge i_clk);
        chk("rst_busy",  32'(bus.o_busy), 32'(0));
        chk("rst_addr",  32'(bus.o_mem_addr), 32'(0));
        chk("rst_write", 32'(bus.o_mem_write), 32'(0));
        chk("rst_data",  32'(bus.o_mem_data), 32'(0));
        chk("rst_vld",   32'(bus.o_rd_data_valid), 32'(0));
        step();
        i_rst = 1'b0;
        step();

        // Streaming reads 0..7: valid two cycles after each accept, in order
        for (int c = 0; c < 12; c++) begin
            bus.i_rd_valid = (c < 8);
            bus.i_rd_addr  = 8'(c);
            @(negedge i_clk);
            chk("strm_rdy", 32'(bus.o_rd_ready), 32'(c < 8));
            chk("strm_vld", 32'(bus.o_rd_data_valid), 32'(c >= 2 && c < 10));
            if (c >= 2 && c < 10) chk("strm_dat", 32'(bus.o_rd_data), 32'((c - 2) ^ 8'h3C));
            step();
        end

        // Reset with reads to 0x10..0x13 in flight
        for (int c = 0; c < 4; c++) begin
            bus.i_rd_valid = 1'b1;
            bus.i_rd_addr  = 8'h10 + 8'(c);
            @(negedge i_clk);
            if (c == 2) begin
                chk("mid_vld", 32'(bus.o_rd_data_valid), 32'(1));
                chk("mid_dat", 32'(bus.o_rd_data), 32'h2C);
            end
            step();
        end
        idle();
        i_rst = 1'b1;
        #1;
        chk("mrst_busy",  32'(bus.o_busy), 32'(0));
        chk("mrst_addr",  32'(bus.o_mem_addr), 32'(0));
        chk("mrst_write", 32'(bus.o_mem_write), 32'(0));
        chk("mrst_data",  32'(bus.o_mem_data), 32'(0));
        chk("mrst_vld",   32'(bus.o_rd_data_valid), 32'(0));
        step();
        i_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            chk("mrst_novld", 32'(bus.o_rd_data_valid), 32'(0));
            step();
        end

        // Single write 0x05 <= 0xA5, then read it back
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 8'h05;
        bus.i_wr_data  = 8'hA5;
        @(negedge i_clk);
        chk("sw_wrdy", 32'(bus.o_wr_ready), 32'(1));
        chk("sw_rrdy", 32'(bus.o_rd_ready), 32'(0));
        step();
        idle();
        @(negedge i_clk);
        chk("sw_write", 32'(bus.o_mem_write), 32'(1));
        chk("sw_addr",  32'(bus.o_mem_addr), 32'h05);
        chk("sw_data",  32'(bus.o_mem_data), 32'hA5);
        step();
        @(negedge i_clk);
        chk("idle_write", 32'(bus.o_mem_write), 32'(0));
        chk("idle_addr",  32'(bus.o_mem_addr), 32'h05);
        chk("idle_data",  32'(bus.o_mem_data), 32'hA5);
        step();
        bus.i_rd_valid = 1'b1;
        bus.i_rd_addr  = 8'h05;
        @(negedge i_clk);
        chk("sr_rrdy", 32'(bus.o_rd_ready), 32'(1));
        step();
        idle();
        @(negedge i_clk);
        chk("sr_write", 32'(bus.o_mem_write), 32'(0));
        chk("sr_early", 32'(bus.o_rd_data_valid), 32'(0));
        step();
        @(negedge i_clk);
        chk("sr_vld", 32'(bus.o_rd_data_valid), 32'(1));
        chk("sr_dat", 32'(bus.o_rd_data), 32'hA5);
        step();
        @(negedge i_clk);
        chk("sr_once", 32'(bus.o_rd_data_valid), 32'(0));
        step();
        step();

        // Contention: R,R,R,R,W,R,R,R,R,W
        for (int c = 0; c < 12; c++) begin
            bus.i_rd_valid = (c < 10);
            bus.i_wr_valid = (c < 10);
            bus.i_rd_addr  = 8'h20 + 8'(c);
            bus.i_wr_addr  = 8'h40 + 8'(c);
            bus.i_wr_data  = 8'h80 + 8'(c);
            @(negedge i_clk);
            if (c < 10) begin
                chk("cont_rd",   32'(bus.o_rd_ready), 32'(!w_pat[c]));
                chk("cont_wr",   32'(bus.o_wr_ready), 32'(w_pat[c]));
                chk("cont_excl", 32'(bus.o_rd_ready & bus.o_wr_ready), 32'(0));
            end
            if (c >= 1 && c <= 10) begin
                chk("cont_cmd",  32'(bus.o_mem_write), 32'(w_pat[c-1]));
                chk("cont_addr", 32'(bus.o_mem_addr),
                    w_pat[c-1] ? 32'(8'h40 + 8'(c - 1)) : 32'(8'h20 + 8'(c - 1)));
            end
            step();
        end
        step();

        // Clear sweep with a read accepted in the clear cycle and a second clear mid-sweep
        bus.i_clear    = 1'b1;
        bus.i_rd_valid = 1'b1;
        bus.i_rd_addr  = 8'h07;
        @(negedge i_clk);
        chk("clr0_rrdy", 32'(bus.o_rd_ready), 32'(1));
        chk("clr0_busy", 32'(bus.o_busy), 32'(0));
        step();
        for (int k = 1; k <= 258; k++) begin
            bus.i_clear    = (k == 100);
            bus.i_rd_valid = (k <= 256);
            bus.i_wr_valid = (k <= 256);
            bus.i_rd_addr  = 8'h30;
            bus.i_wr_addr  = 8'h50;
            bus.i_wr_data  = 8'hEE;
            @(negedge i_clk);
            chk("clr_busy", 32'(bus.o_busy), 32'(k <= 256));
            if (k <= 256) chk("clr_rdy", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(0));
            if (k == 1) begin
                chk("clr_rdcmd_w", 32'(bus.o_mem_write), 32'(0));
                chk("clr_rdcmd_a", 32'(bus.o_mem_addr), 32'h07);
            end else if (k <= 257) begin
                chk("clr_write", 32'(bus.o_mem_write), 32'(1));
                chk("clr_addr",  32'(bus.o_mem_addr), 32'(k - 2));
                chk("clr_data",  32'(bus.o_mem_data), 32'(0));
            end else begin
                chk("clr_end_w", 32'(bus.o_mem_write), 32'(0));
                chk("clr_end_a", 32'(bus.o_mem_addr), 32'hFF);
            end
            chk("clr_vld", 32'(bus.o_rd_data_valid), 32'(k == 2));
            if (k == 2) chk("clr_rddat", 32'(bus.o_rd_data), 32'h3B);
            step();
        end
        idle();

        // Cleared words read back as zero, back to back
        bus.i_rd_valid = 1'b1;
        bus.i_rd_addr  = 8'h44;
        step();
        bus.i_rd_addr  = 8'h07;
        step();
        idle();
        @(negedge i_clk);
        chk("pc_vld0", 32'(bus.o_rd_data_valid), 32'(1));
        chk("pc_dat0", 32'(bus.o_rd_data), 32'(0));
        step();
        @(negedge i_clk);
        chk("pc_vld1", 32'(bus.o_rd_data_valid), 32'(1));
        chk("pc_dat1", 32'(bus.o_rd_data), 32'(0));
        step();
        @(negedge i_clk);
        chk("pc_vld2", 32'(bus.o_rd_data_valid), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
